// File: rtl/lsu_ctrl_if.sv
// Bus side of the load/store unit: a single request held stable until ack or err.
interface lsu_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned SEL_W = DATA_W / 8;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [SEL_W-1:0]  bus_sel;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic              bus_err;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_ack, bus_err, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_ack, bus_err, bus_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: alignment check, lane steering, store replication, load extension,
// bus timeout and flush-abort, with one-cycle done/exception reporting.
module lsu_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_store,
  input  logic [1:0]        op_size,
  input  logic              op_uns,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  input  logic              flush,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              excp_o,
  output logic [4:0]        exc_code_o,
  output logic [ADDR_W-1:0] bad_addr_o,
  lsu_ctrl_if.master        bus
);
  localparam int unsigned SEL_W   = DATA_W / 8;
  localparam int unsigned OFF_W   = $clog2(SEL_W);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d, uns_q, uns_d, abort_q, abort_d;
  logic [1:0]        size_q, size_d;
  logic [2:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d, bad_q, bad_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [4:0]        code_q, code_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [OFF_W-1:0]  op_off;
  logic              misalign;
  logic [2:0]        op_shift;
  logic [7:0]        nmask;
  logic [15:0]       sel_wide;
  logic [DATA_W-1:0] wdata_rep, rd_shift, keep, ld_val;
  logic              sign;

  assign op_off = op_addr[OFF_W-1:0];

  always_comb begin
    misalign  = 1'b0;
    nmask     = 8'h01;
    wdata_rep = {SEL_W{op_wdata[7:0]}};
    unique case (op_size)
      2'd0: misalign = 1'b0;
      2'd1: begin
        misalign  = op_addr[0];
        nmask     = 8'h03;
        wdata_rep = {(SEL_W / 2){op_wdata[15:0]}};
      end
      2'd2: begin
        misalign  = |op_addr[1:0];
        nmask     = 8'h0F;
        wdata_rep = {(SEL_W / 4){op_wdata[31:0]}};
      end
      default: begin
        misalign  = (DATA_W == 32) || (|op_addr[2:0]);
        nmask     = 8'hFF;
        wdata_rep = op_wdata;
      end
    endcase
    // op_shift is the lowest bus lane touched; big-endian puts the lowest byte in the top lane.
    if (BIG_ENDIAN) op_shift = 3'(SEL_W - 32'(op_off) - (32'd1 << op_size));
    else            op_shift = 3'(op_off);
    sel_wide = 16'(nmask) << op_shift;
  end

  // Once shifted down, the selected bytes are already in value order for either endianness.
  always_comb begin
    rd_shift = bus.bus_rdata >> {shift_q, 3'b000};
    unique case (size_q)
      2'd0: begin
        keep = {DATA_W{1'b1}} >> (DATA_W - 8);
        sign = rd_shift[7];
      end
      2'd1: begin
        keep = {DATA_W{1'b1}} >> (DATA_W - 16);
        sign = rd_shift[15];
      end
      2'd2: begin
        keep = {DATA_W{1'b1}} >> (DATA_W - 32);
        sign = rd_shift[31];
      end
      default: begin
        keep = {DATA_W{1'b1}};
        sign = rd_shift[DATA_W-1];
      end
    endcase
    ld_val = rd_shift & keep;
    if (!uns_q && sign) ld_val = ld_val | ~keep;
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uns_d   = uns_q;
    abort_d = abort_q;
    size_d  = size_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    bad_d   = bad_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (op_valid && !flush) begin
          bad_d   = op_addr;
          abort_d = 1'b0;
          cnt_d   = '0;
          rdata_d = '0;
          if (misalign) begin
            state_d = StErr;
            code_d  = op_store ? 5'd5 : 5'd4;
          end else begin
            state_d = StReq;
            we_d    = op_store;
            size_d  = op_size;
            uns_d   = op_uns;
            shift_d = op_shift;
            addr_d  = {op_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            sel_d   = sel_wide[SEL_W-1:0];
            wdata_d = op_store ? wdata_rep : '0;
          end
        end
      end
      StReq: begin
        abort_d = abort_q | flush;
        if (bus.bus_err) begin
          state_d = abort_d ? StIdle : StErr;
          code_d  = 5'd7;
        end else if (bus.bus_ack) begin
          state_d = abort_d ? StIdle : StDone;
          rdata_d = we_q ? '0 : ld_val;
        end else if (cnt_q == TO_LAST) begin
          state_d = abort_d ? StIdle : StErr;
          code_d  = 5'd7;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      abort_q <= 1'b0;
      size_q  <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      bad_q   <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      abort_q <= abort_d;
      size_q  <= size_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      bad_q   <= bad_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  // stall_o is gated by rst so every output reads zero while reset is held.
  assign stall_o       = rst && ((state_q == StIdle && op_valid && !flush) || state_q == StReq);
  assign done_o        = (state_q == StDone) || (state_q == StErr);
  assign excp_o        = (state_q == StErr);
  assign exc_code_o    = excp_o ? code_q : '0;
  assign bad_addr_o    = excp_o ? bad_q : '0;
  assign rdata_o       = (state_q == StDone) ? rdata_q : '0;
  assign bus.bus_req   = (state_q == StReq);
  assign bus.bus_we    = bus.bus_req && we_q;
  assign bus.bus_addr  = bus.bus_req ? addr_q : '0;
  assign bus.bus_sel   = bus.bus_req ? sel_q : '0;
  assign bus.bus_wdata = bus.bus_req ? wdata_q : '0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: three configurations (32 BE timeout 4, 32 LE, 64 BE),
// directed ops push expected bus/completion records; a negedge monitor pops and compares.
module tb_lsu_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int          act;
  logic        op_valid, op_store, op_uns, flush, ack, err;
  logic [1:0]  op_size;
  logic [31:0] op_addr;
  logic [63:0] op_wdata, rdata;

  logic [2:0]  stall_v, done_v, excp_v;
  logic [4:0]  code_v [3];
  logic [31:0] bad_v [3];
  logic [31:0] rdata_a, rdata_b;
  logic [63:0] rdata_c;

  lsu_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
  lsu_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus_b ();
  lsu_ctrl_if #(.DATA_W(64), .ADDR_W(32)) bus_c ();

  assign bus_a.bus_ack   = ack && act == 0;
  assign bus_a.bus_err   = err && act == 0;
  assign bus_a.bus_rdata = rdata[31:0];
  assign bus_b.bus_ack   = ack && act == 1;
  assign bus_b.bus_err   = err && act == 1;
  assign bus_b.bus_rdata = rdata[31:0];
  assign bus_c.bus_ack   = ack && act == 2;
  assign bus_c.bus_err   = err && act == 2;
  assign bus_c.bus_rdata = rdata;

  lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(4)) u_a (
    .clk(clk), .rst(rst), .op_valid(op_valid && act == 0), .op_store(op_store),
    .op_size(op_size), .op_uns(op_uns), .op_addr(op_addr), .op_wdata(op_wdata[31:0]),
    .flush(flush), .stall_o(stall_v[0]), .done_o(done_v[0]), .rdata_o(rdata_a),
    .excp_o(excp_v[0]), .exc_code_o(code_v[0]), .bad_addr_o(bad_v[0]), .bus(bus_a)
  );
  lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(255)) u_b (
    .clk(clk), .rst(rst), .op_valid(op_valid && act == 1), .op_store(op_store),
    .op_size(op_size), .op_uns(op_uns), .op_addr(op_addr), .op_wdata(op_wdata[31:0]),
    .flush(flush), .stall_o(stall_v[1]), .done_o(done_v[1]), .rdata_o(rdata_b),
    .excp_o(excp_v[1]), .exc_code_o(code_v[1]), .bad_addr_o(bad_v[1]), .bus(bus_b)
  );
  lsu_ctrl #(.DATA_W(64), .ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(255)) u_c (
    .clk(clk), .rst(rst), .op_valid(op_valid && act == 2), .op_store(op_store),
    .op_size(op_size), .op_uns(op_uns), .op_addr(op_addr), .op_wdata(op_wdata),
    .flush(flush), .stall_o(stall_v[2]), .done_o(done_v[2]), .rdata_o(rdata_c),
    .excp_o(excp_v[2]), .exc_code_o(code_v[2]), .bad_addr_o(bad_v[2]), .bus(bus_c)
  );

  // View of whichever instance is currently active.
  logic        m_req, m_we, m_stall, m_done, m_excp;
  logic [31:0] m_addr, m_bad;
  logic [7:0]  m_sel;
  logic [63:0] m_wdata, m_rdata;
  logic [4:0]  m_code;

  always_comb begin
    m_req = bus_a.bus_req; m_we = bus_a.bus_we; m_addr = bus_a.bus_addr;
    m_sel = {4'h0, bus_a.bus_sel}; m_wdata = {32'h0, bus_a.bus_wdata};
    m_rdata = {32'h0, rdata_a};
    if (act == 1) begin
      m_req = bus_b.bus_req; m_we = bus_b.bus_we; m_addr = bus_b.bus_addr;
      m_sel = {4'h0, bus_b.bus_sel}; m_wdata = {32'h0, bus_b.bus_wdata};
      m_rdata = {32'h0, rdata_b};
    end else if (act == 2) begin
      m_req = bus_c.bus_req; m_we = bus_c.bus_we; m_addr = bus_c.bus_addr;
      m_sel = bus_c.bus_sel; m_wdata = bus_c.bus_wdata; m_rdata = rdata_c;
    end
    m_stall = stall_v[act];
    m_done  = done_v[act];
    m_excp  = excp_v[act];
    m_code  = code_v[act];
    m_bad   = bad_v[act];
  end

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  sel;
    logic [63:0] wdata;
    logic        we;
  } bus_exp_t;

  typedef struct {
    logic        done;
    logic        excp;
    logic [4:0]  code;
    logic [31:0] bad;
    logic [63:0] rdata;
    int          reqs;
  } cpl_exp_t;

  bus_exp_t bus_q[$];
  cpl_exp_t cpl_q[$];
  int total = 0;
  int nbad  = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endfunction

  function automatic void exp_bus(logic [31:0] a, logic [7:0] s, logic [63:0] w, logic we);
    bus_q.push_back('{addr: a, sel: s, wdata: w, we: we});
  endfunction

  function automatic void exp_cpl(logic d, logic e, logic [4:0] c, logic [31:0] b,
                                  logic [63:0] r, int n);
    cpl_q.push_back('{done: d, excp: e, code: c, bad: b, rdata: r, reqs: n});
  endfunction

  // Monitor: checks bus outputs when a request starts and while it is held, and the
  // completion whenever done_o pulses or a request ends without one.
  logic        req_prev = 1'b0;
  int          req_cnt  = 0;
  logic [40:0] snap_ctl;
  logic [63:0] snap_wdata;

  always @(negedge clk) begin
    bus_exp_t be;
    cpl_exp_t ce;
    if (m_req && !req_prev) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", 64'(m_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        be = bus_q.pop_front();
        chk("bus_addr", 64'(m_addr), 64'(be.addr));
        chk("bus_sel", 64'(m_sel), 64'(be.sel));
        chk("bus_wdata", m_wdata, be.wdata);
        chk("bus_we", 64'(m_we), 64'(be.we));
      end
      snap_ctl   = {m_sel, m_we, m_addr};
      snap_wdata = m_wdata;
    end else if (m_req) begin
      chk("bus_hold_ctl", 64'({m_sel, m_we, m_addr}), 64'(snap_ctl));
      chk("bus_hold_wdata", m_wdata, snap_wdata);
    end
    if (m_req) begin
      req_cnt++;
      chk("stall_in_req", 64'(m_stall), 64'd1);
    end
    if (m_done || (req_prev && !m_req)) begin
      if (cpl_q.size() == 0) begin
        chk("cpl_unexpected", 64'(m_done), 64'd0);
      end else begin
        ce = cpl_q.pop_front();
        chk("cpl_done", 64'(m_done), 64'(ce.done));
        chk("cpl_excp", 64'(m_excp), 64'(ce.excp));
        chk("cpl_code", 64'(m_code), 64'(ce.code));
        chk("cpl_bad", 64'(m_bad), 64'(ce.bad));
        chk("cpl_rdata", m_rdata, ce.rdata);
        chk("cpl_req_cycles", 64'(req_cnt), 64'(ce.reqs));
        chk("cpl_stall", 64'(m_stall), 64'd0);
      end
      req_cnt = 0;
    end
    req_prev = m_req;
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(int d, logic st, logic [1:0] sz, logic un, logic [31:0] ad,
                       logic [63:0] wd);
    act = d; op_store = st; op_size = sz; op_uns = un; op_addr = ad; op_wdata = wd;
    op_valid = 1'b1;
    idle(1);
    op_valid = 1'b0;
  endtask

  // Called in REQ cycle 1; raises the response during REQ cycle m.
  task automatic ack_at(int m, logic [63:0] rd, logic a, logic e);
    idle(m - 1);
    rdata = rd; ack = a; err = e;
    idle(1);
    ack = 1'b0; err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; act = 0; op_valid = 1'b1; op_store = 1'b0; op_size = 2'd0; op_uns = 1'b0;
    op_addr = 32'h0; op_wdata = 64'h0; flush = 1'b0; ack = 1'b0; err = 1'b0; rdata = 64'h0;
    repeat (2) @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      act = d;
      #1;
      chk("rst_stall", 64'(m_stall), 64'd0);
      chk("rst_done", 64'(m_done), 64'd0);
      chk("rst_excp", 64'(m_excp), 64'd0);
      chk("rst_req", 64'(m_req), 64'd0);
      chk("rst_rdata", m_rdata, 64'd0);
    end
    op_valid = 1'b0;
    act = 0;
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // 32-bit big-endian, TIMEOUT=4
    exp_bus(32'h1000, 8'h04, 64'h0, 1'b0); exp_cpl(1, 0, 0, 0, 64'hFFFF_FFF3, 1);
    issue(0, 0, 2'd0, 0, 32'h1001, 64'h0); ack_at(1, 64'h12F3_5678, 1, 0); idle(2);
    exp_bus(32'h1000, 8'h04, 64'h0, 1'b0); exp_cpl(1, 0, 0, 0, 64'h0000_00F3, 1);
    issue(0, 0, 2'd0, 1, 32'h1001, 64'h0); ack_at(1, 64'h12F3_5678, 1, 0); idle(2);
    exp_bus(32'h1000, 8'h03, 64'h0, 1'b0); exp_cpl(1, 0, 0, 0, 64'hFFFF_8001, 1);
    issue(0, 0, 2'd1, 0, 32'h1002, 64'h0); ack_at(1, 64'hAAAA_8001, 1, 0); idle(2);

    // Misaligned load, op_valid left high through ERR
    exp_cpl(1, 1, 5'd4, 32'h3002, 64'h0, 0);
    act = 0; op_store = 1'b0; op_size = 2'd2; op_uns = 1'b0; op_addr = 32'h3002;
    op_valid = 1'b1; idle(2); op_valid = 1'b0; idle(2);
    exp_cpl(1, 1, 5'd5, 32'h3001, 64'h0, 0);
    issue(0, 1, 2'd1, 0, 32'h3001, 64'h1234); idle(2);
    exp_cpl(1, 1, 5'd4, 32'h4000, 64'h0, 0);
    issue(0, 0, 2'd3, 0, 32'h4000, 64'h0); idle(2);

    exp_bus(32'h5004, 8'h0F, 64'h0, 1'b0); exp_cpl(1, 1, 5'd7, 32'h5004, 64'h0, 4);
    issue(0, 0, 2'd2, 0, 32'h5004, 64'h0); idle(6);
    exp_bus(32'h5008, 8'h0F, 64'h0, 1'b0); exp_cpl(1, 0, 0, 0, 64'hCAFE_F00D, 4);
    issue(0, 0, 2'd2, 0, 32'h5008, 64'h0); ack_at(4, 64'hCAFE_F00D, 1, 0); idle(2);
    exp_bus(32'h600C, 8'h0F, 64'h0, 1'b0); exp_cpl(1, 1, 5'd7, 32'h600C, 64'h0, 2);
    issue(0, 0, 2'd2, 0, 32'h600C, 64'h0); ack_at(2, 64'h1, 1, 1); idle(2);
    exp_bus(32'h7000, 8'h01, 64'h5A5A_5A5A, 1'b1); exp_cpl(1, 0, 0, 0, 64'h0, 1);
    issue(0, 1, 2'd0, 0, 32'h7003, 64'h5A); ack_at(1, 64'hFFFF_FFFF, 1, 0); idle(2);

    // 32-bit little-endian
    exp_bus(32'h2000, 8'h0C, 64'hABCD_ABCD, 1'b1); exp_cpl(1, 0, 0, 0, 64'h0, 2);
    issue(1, 1, 2'd1, 0, 32'h2002, 64'hABCD); ack_at(2, 64'h5555_5555, 1, 0); idle(2);
    exp_bus(32'h2000, 8'h0C, 64'h0, 1'b0); exp_cpl(1, 0, 0, 0, 64'h0000_7FFE, 1);
    issue(1, 0, 2'd1, 0, 32'h2002, 64'h0); ack_at(1, 64'h7FFE_1234, 1, 0); idle(2);

    // Flush in IDLE blocks acceptance
    act = 1; op_store = 1'b0; op_size = 2'd2; op_addr = 32'h2300; op_valid = 1'b1; flush = 1'b1;
    #1 chk("flush_idle_stall", 64'(m_stall), 64'd0);
    idle(1);
    chk("flush_idle_req", 64'(m_req), 64'd0);
    op_valid = 1'b0; flush = 1'b0; idle(2);

    // Flush in REQ cycle 2, ack in cycle 5: silent return to IDLE
    exp_bus(32'h2100, 8'h0F, 64'h0, 1'b0); exp_cpl(0, 0, 0, 0, 64'h0, 5);
    issue(1, 0, 2'd2, 0, 32'h2100, 64'h0); idle(1); flush = 1'b1; idle(1); flush = 1'b0;
    ack_at(3, 64'h1111_2222, 1, 0); idle(3);

    // Reset during REQ
    exp_bus(32'h2200, 8'h0F, 64'h0, 1'b0); exp_cpl(0, 0, 0, 0, 64'h0, 1);
    issue(1, 0, 2'd2, 0, 32'h2200, 64'h0); idle(1); rst = 1'b0;
    #1 chk("rst_in_req_drop", 64'(m_req), 64'd0);
    idle(2); rst = 1'b1; idle(2);

    // 64-bit big-endian
    exp_bus(32'h8, 8'hFF, 64'h0, 1'b0); exp_cpl(1, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 1);
    issue(2, 0, 2'd3, 0, 32'h8, 64'h0); ack_at(1, 64'h0123_4567_89AB_CDEF, 1, 0); idle(2);
    exp_bus(32'h8, 8'h03, 64'h0, 1'b0); exp_cpl(1, 0, 0, 0, 64'h8001, 1);
    issue(2, 0, 2'd1, 1, 32'hE, 64'h0); ack_at(1, 64'h1111_2222_3333_8001, 1, 0); idle(2);
    exp_bus(32'h10, 8'h0F, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1); exp_cpl(1, 0, 0, 0, 64'h0, 1);
    issue(2, 1, 2'd2, 0, 32'h14, 64'hDEAD_BEEF); ack_at(1, 64'h0, 1, 0); idle(2);
    exp_bus(32'h0, 8'h0F, 64'h0, 1'b0); exp_cpl(1, 0, 0, 0, 64'hFFFF_FFFF_8765_4321, 1);
    issue(2, 0, 2'd2, 0, 32'h4, 64'h0); ack_at(1, 64'h0000_0000_8765_4321, 1, 0); idle(3);

    chk("bus_queue_left", 64'(bus_q.size()), 64'd0);
    chk("cpl_queue_left", 64'(cpl_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end
endmodule
